lz4_buf_feeder: RTL and testbench

LZ4_BUF_FEEDER -- requirements
Module: lz4_buf_feeder

---
 rtl/lz4_buf_feeder.sv | 172 +++++++++++++++++
 tb/tb_lz4_buf_feeder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lz4_buf_feeder.sv
// ---------------------------------------------------------------------------
// lz4_buf_feeder
//
// Packs a byte stream into 32-bit little-endian words and writes them into a
// downstream buffer at consecutive byte addresses. A block begins with a
// one-cycle start pulse. The block ends with the byte flagged by in_last.
// After the final word has been written, compress_end pulses for one cycle.
//
// Ports
//   clk           single clock; all state changes on the rising edge
//   rstN          asynchronous active-low reset
//   start         one-cycle pulse that begins a block (seen only in IDLE)
//   in_data       source byte
//   in_valid      in_data valid
//   in_last       marks the final byte of the block (qualified by in_valid)
//   in_ready      feeder accepts a byte this cycle
//   buf_clean     one-cycle clear pulse to the buffer at block start
//   buf_idword    packed data word
//   buf_idvalid   one-cycle write strobe for buf_idword / buf_waddr
//   buf_waddr     byte address of the current word
//   buf_full      buffer cannot accept a write
//   buf_unable    buffer busy/cleaning; handled the same as buf_full
//   compress_end  one-cycle pulse after the last word of a block is written
//   byte_count    bytes accepted in the current or most recent block
//   busy          high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module lz4_buf_feeder #(
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        buf_clean,
  output logic [31:0] buf_idword,
  output logic        buf_idvalid,
  output logic [31:0] buf_waddr,
  input  logic        buf_full,
  input  logic        buf_unable,
  output logic        compress_end,
  output logic [31:0] byte_count,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    END   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  lane;
  logic [31:0] pack;
  logic        last_seen;

  logic        begin_blk;
  logic        accept;
  logic        drain;
  logic        word_done;

  // Places byte b into lane idx of word. Lane 0 is bits [7:0].
  function automatic logic [31:0] put_lane(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  assign begin_blk = (state == IDLE) && start;
  assign accept    = (state == FILL) && in_valid;
  assign word_done = accept && ((lane == 2'd3) || in_last);
  assign drain     = (state == WRITE) && !buf_full && !buf_unable;

  // ---- state register ----
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- next state and combinational outputs ----
  // END is entered together with the final strobe. It waits out the strobe
  // cycle, so compress_end never coincides with buf_idvalid.
  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    compress_end = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (word_done) state_nxt = WRITE;
      end
      WRITE: begin
        if (drain) state_nxt = last_seen ? END : FILL;
      end
      END: begin
        if (!buf_idvalid) begin
          compress_end = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- control / output registers ----
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      buf_clean   <= 1'b0;
      buf_idvalid <= 1'b0;
      buf_idword  <= '0;
      buf_waddr   <= '0;
      byte_count  <= '0;
      last_seen   <= 1'b0;
    end else begin
      buf_clean   <= begin_blk;
      buf_idvalid <= drain;

      if (drain) buf_idword <= pack;

      // The address moves on only after the strobe cycle. The strobe then
      // pairs with the address of the word being written.
      if (begin_blk) begin
        buf_waddr <= '0;
      end else if (buf_idvalid) begin
        buf_waddr <= buf_waddr + 32'(ADDR_STEP);
      end

      if (begin_blk) begin
        byte_count <= '0;
      end else if (accept) begin
        byte_count <= byte_count + 32'd1;
      end

      if (begin_blk) begin
        last_seen <= 1'b0;
      end else if (accept) begin
        last_seen <= in_last;
      end
    end
  end

  // ---- pack register (datapath) ----
  // Clearing on drain leaves unused upper lanes of a short final word at zero.
  always_ff @(posedge clk) begin
    if (begin_blk || drain) begin
      pack <= '0;
      lane <= 2'd0;
    end else if (accept) begin
      pack <= put_lane(pack, lane, in_data);
      lane <= lane + 2'd1;
    end
  end

  strobe_end_exclusive: assert property (@(posedge clk) disable iff (!rstN)
    !(buf_idvalid && compress_end));

endmodule

// File: tb/tb_lz4_buf_feeder.sv
module tb_lz4_buf_feeder;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        buf_clean;
  logic [31:0] buf_idword;
  logic        buf_idvalid;
  logic [31:0] buf_waddr;
  logic        buf_full = 1'b0;
  logic        buf_unable = 1'b0;
  logic        compress_end;
  logic [31:0] byte_count;
  logic        busy;

  always #5 clk = ~clk;

  lz4_buf_feeder #(.ADDR_STEP(4)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .buf_clean    (buf_clean),
    .buf_idword   (buf_idword),
    .buf_idvalid  (buf_idvalid),
    .buf_waddr    (buf_waddr),
    .buf_full     (buf_full),
    .buf_unable   (buf_unable),
    .compress_end (compress_end),
    .byte_count   (byte_count),
    .busy         (busy)
  );

  int checks = 0;
  int passes = 0;

  // Scoreboard entries are {waddr, word}.
  logic [63:0] exp_q[$];
  logic [31:0] m_pack = 0;
  int          m_lane = 0;
  logic [31:0] m_addr = 0;
  int          m_bytes = 0;

  int strobe_cnt = 0;
  int ce_cnt = 0;
  int cyc = 0;
  int last_strobe_cyc = 0;
  int strobe_gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [63:0] e;
    if (rstN && buf_idvalid) begin
      strobe_gap = cyc - last_strobe_cyc;
      last_strobe_cyc = cyc;
      strobe_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL strobe_unexpected: got addr=%h word=%h, required no strobe", buf_waddr, buf_idword);
      end else begin
        e = exp_q.pop_front();
        if ({buf_waddr, buf_idword} !== e)
          $display("FAIL strobe_word: got addr=%h word=%h, required addr=%h word=%h",
                   buf_waddr, buf_idword, e[63:32], e[31:0]);
        else
          passes++;
      end
      checks++;
      if (compress_end !== 1'b0)
        $display("FAIL strobe_end_overlap: got compress_end=%b, required 0", compress_end);
      else
        passes++;
    end
    if (rstN && compress_end) ce_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_clear();
    m_pack = 0; m_lane = 0; m_addr = 0; m_bytes = 0;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    model_clear();
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last);
    bit ok;
    ok = 1'b0;
    in_data = d; in_valid = 1'b1; in_last = last;
    for (int g = 0; g < 40 && !ok; g++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      checks++;
      $display("FAIL send_timeout: got in_ready=0 for 40 cycles, required acceptance of %h", d);
    end
    m_pack = m_pack | (32'(d) << (8 * m_lane));
    m_lane++;
    m_bytes++;
    if (m_lane == 4 || last) begin
      exp_q.push_back({m_addr, m_pack});
      m_addr = m_addr + 32'd4;
      m_pack = 0;
      m_lane = 0;
    end
  endtask

  task automatic send_seq(input logic [7:0] first, input logic [7:0] step, input int n);
    logic [7:0] d;
    d = first;
    for (int i = 0; i < n; i++) begin
      send_byte(d, i == n - 1);
      d = d + step;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int ce_before);
    int g;
    g = 0;
    while (ce_cnt == ce_before && g < 60) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (ce_cnt == ce_before) $display("FAIL %s_done_timeout: got no compress_end, required one", tag);
    else passes++;
    repeat (3) @(negedge clk);
    checks++;
    if (ce_cnt !== ce_before + 1) $display("FAIL %s_end_pulses: got %0d, required 1", tag, ce_cnt - ce_before);
    else passes++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL %s_pending_words: got %0d left, required 0", tag, exp_q.size());
    else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL %s_idle_busy: got %b, required 0", tag, busy);
    else passes++;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b required 0", in_ready); else passes++;
    checks++; if (buf_clean !== 1'b0) $display("FAIL rst_buf_clean: got %b required 0", buf_clean); else passes++;
    checks++; if (buf_idword !== 32'h0) $display("FAIL rst_idword: got %h required 0", buf_idword); else passes++;
    checks++; if (buf_idvalid !== 1'b0) $display("FAIL rst_idvalid: got %b required 0", buf_idvalid); else passes++;
    checks++; if (buf_waddr !== 32'h0) $display("FAIL rst_waddr: got %h required 0", buf_waddr); else passes++;
    checks++; if (compress_end !== 1'b0) $display("FAIL rst_compress_end: got %b required 0", compress_end); else passes++;
    checks++; if (byte_count !== 32'h0) $display("FAIL rst_byte_count: got %h required 0", byte_count); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else passes++;
    @(negedge clk); rstN = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, buf_clean, in_ready, buf_idvalid, buf_waddr, byte_count} !== 68'h0)
      $display("FAIL post_rst_quiet: got busy=%b clean=%b rdy=%b vld=%b addr=%h cnt=%h required all 0",
               busy, buf_clean, in_ready, buf_idvalid, buf_waddr, byte_count);
    else passes++;
  endtask

  task automatic test_eight_bytes();
    int ce0, s0;
    ce0 = ce_cnt; s0 = strobe_cnt;
    do_start();
    checks++; if (buf_clean !== 1'b1) $display("FAIL eight_clean_pulse: got %b required 1", buf_clean); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL eight_busy: got %b required 1", busy); else passes++;
    @(posedge clk); #1;
    checks++; if (buf_clean !== 1'b0) $display("FAIL eight_clean_width: got %b required 0", buf_clean); else passes++;
    send_seq(8'h11, 8'h11, 8);
    wait_done("eight", ce0);
    checks++; if (byte_count !== 32'd8) $display("FAIL eight_byte_count: got %0d required 8", byte_count); else passes++;
    checks++; if (strobe_cnt - s0 !== 2) $display("FAIL eight_strobes: got %0d required 2", strobe_cnt - s0); else passes++;
    checks++; if (buf_waddr !== 32'd8) $display("FAIL eight_final_waddr: got %h required 8", buf_waddr); else passes++;
  endtask

  task automatic test_partial();
    int ce0;
    ce0 = ce_cnt;
    do_start();
    send_seq(8'h11, 8'h11, 5);
    wait_done("partial", ce0);
    checks++; if (byte_count !== 32'd5) $display("FAIL partial_byte_count: got %0d required 5", byte_count); else passes++;
  endtask

  task automatic test_full_hold(input bit use_unable);
    int ce0, s0, bad;
    string tag;
    tag = use_unable ? "unable" : "full";
    ce0 = ce_cnt;
    do_start();
    if (use_unable) buf_unable = 1'b1; else buf_full = 1'b1;
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    s0 = strobe_cnt;
    in_data = 8'h01; in_valid = 1'b1; in_last = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (buf_idvalid || in_ready || !busy) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL %s_hold: got %0d bad cycles, required 0", tag, bad); else passes++;
    checks++; if (strobe_cnt !== s0) $display("FAIL %s_no_strobe: got %0d strobes, required 0", tag, strobe_cnt - s0); else passes++;
    buf_full = 1'b0; buf_unable = 1'b0;
    send_byte(8'h01, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_done(tag, ce0);
    checks++; if (strobe_cnt - s0 !== 2) $display("FAIL %s_strobes: got %0d required 2", tag, strobe_cnt - s0); else passes++;
    checks++; if (byte_count !== 32'd5) $display("FAIL %s_byte_count: got %0d required 5", tag, byte_count); else passes++;
  endtask

  task automatic test_back_to_back();
    int ce0, s0;
    ce0 = ce_cnt; s0 = strobe_cnt;
    do_start();
    send_seq(8'h01, 8'h01, 12);
    wait_done("b2b", ce0);
    checks++; if (strobe_cnt - s0 !== 3) $display("FAIL b2b_strobes: got %0d required 3", strobe_cnt - s0); else passes++;
    checks++; if (strobe_gap !== 5) $display("FAIL b2b_strobe_gap: got %0d cycles required 5", strobe_gap); else passes++;
    checks++; if (byte_count !== 32'd12) $display("FAIL b2b_byte_count: got %0d required 12", byte_count); else passes++;
  endtask

  task automatic test_reset_mid_fill();
    int ce0;
    do_start();
    send_byte(8'h5A, 1'b0);
    send_byte(8'h6B, 1'b0);
    in_valid = 1'b0;
    @(negedge clk); rstN = 1'b0;
    #1;
    checks++; if (byte_count !== 32'h0) $display("FAIL midrst_byte_count: got %h required 0", byte_count); else passes++;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL midrst_busy_ready: got busy=%b rdy=%b required 0", busy, in_ready); else passes++;
    checks++; if (buf_idword !== 32'h0 || buf_waddr !== 32'h0) $display("FAIL midrst_word_addr: got word=%h addr=%h required 0", buf_idword, buf_waddr); else passes++;
    checks++; if ({buf_clean, buf_idvalid, compress_end} !== 3'b000) $display("FAIL midrst_pulses: got %b required 000", {buf_clean, buf_idvalid, compress_end}); else passes++;
    exp_q.delete();
    model_clear();
    @(negedge clk); rstN = 1'b1;
    ce0 = ce_cnt;
    do_start();
    checks++; if (buf_waddr !== 32'h0 || byte_count !== 32'h0) $display("FAIL midrst_restart: got addr=%h cnt=%h required 0", buf_waddr, byte_count); else passes++;
    send_seq(8'hA1, 8'h01, 4);
    wait_done("midrst", ce0);
    checks++; if (byte_count !== 32'd4) $display("FAIL midrst_byte_count2: got %0d required 4", byte_count); else passes++;
  endtask

  task automatic test_ignored();
    int ce0, bad;
    bad = 0;
    in_data = 8'h99; in_valid = 1'b1; in_last = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (in_ready || busy) bad++;
    end
    in_valid = 1'b0;
    checks++; if (bad !== 0) $display("FAIL ign_idle_ready: got %0d bad cycles required 0", bad); else passes++;
    checks++; if (byte_count !== 32'd4) $display("FAIL ign_idle_count: got %0d required 4", byte_count); else passes++;
    ce0 = ce_cnt;
    do_start();
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checks++; if (buf_clean !== 1'b0) $display("FAIL ign_fill_clean: got %b required 0", buf_clean); else passes++;
    checks++; if (byte_count !== 32'd2) $display("FAIL ign_fill_count: got %0d required 2", byte_count); else passes++;
    send_byte(8'h30, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_done("ign", ce0);
    checks++; if (byte_count !== 32'd3) $display("FAIL ign_byte_count: got %0d required 3", byte_count); else passes++;
  endtask

  initial begin
    test_reset();
    test_eight_bytes();
    test_partial();
    test_full_hold(1'b0);
    test_full_hold(1'b1);
    test_back_to_back();
    test_reset_mid_fill();
    test_ignored();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
